// File: rtl/stopwatch_control.sv
// Stopwatch button front-end: per-button sync, debounce and press detect,
// feeding the run-control FSM that drives the BCD counter and display freeze.
//
// state   | meaning
// IDLE    | stopped and cleared, waiting for start
// RUNNING | counter enabled
// PAUSED  | counter held, can resume or be cleared
// LAP     | counter enabled, display frozen on the lap time
module stopwatch_control #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic       clkIn,
   input  logic       rstIn,
   input  logic       startStopBtnIn,
   input  logic       resetBtnIn,
   input  logic       lapBtnIn,
   output logic       enCounterOut,
   output logic       clrCounterOut,
   output logic       freezeDisplayOut,
   output logic [1:0] stateOut
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam int BTN_SS  = 0;
   localparam int BTN_RST = 1;
   localparam int BTN_LAP = 2;

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_RUNNING = 2'b01,
      S_PAUSED  = 2'b10,
      S_LAP     = 2'b11
   } state_t;

   logic [2:0]       w_btn_raw;
   logic [2:0]       r_sync1;
   logic [2:0]       r_sync2;
   logic [2:0]       r_db;
   logic [2:0]       r_db_q;
   logic [2:0]       r_press;
   logic [CNT_W-1:0] r_cnt [3];

   state_t r_state;
   state_t w_state_nxt;
   logic   w_clr_nxt;
   logic   r_en;
   logic   r_clr;
   logic   r_frz;

   assign w_btn_raw = {lapBtnIn, resetBtnIn, startStopBtnIn};

   // The flip happens on the cycle the counter would reach DEBOUNCE_CYCLES,
   // so it stops at CNT_LAST and never wraps.
   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_db    <= '0;
         r_db_q  <= '0;
         r_press <= '0;
         for (int i = 0; i < 3; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_sync1 <= w_btn_raw;
         r_sync2 <= r_sync1;
         r_db_q  <= r_db;
         r_press <= r_db & ~r_db_q;
         for (int i = 0; i < 3; i++) begin
            if (r_sync2[i] == r_db[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
               r_db[i]  <= ~r_db[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CNT_ONE;
            end
         end
      end
   end

   // Only the highest-priority pulse is considered; lower ones are dropped
   // even when the winning press is ignored in the current state.
   always_comb begin
      w_state_nxt = r_state;
      w_clr_nxt   = 1'b0;
      if (r_press[BTN_RST]) begin
         if (r_state == S_IDLE) begin
            w_clr_nxt = 1'b1;
         end else if (r_state == S_PAUSED) begin
            w_state_nxt = S_IDLE;
            w_clr_nxt   = 1'b1;
         end
      end else if (r_press[BTN_SS]) begin
         case (r_state)
            S_IDLE:    w_state_nxt = S_RUNNING;
            S_RUNNING: w_state_nxt = S_PAUSED;
            S_LAP:     w_state_nxt = S_PAUSED;
            S_PAUSED:  w_state_nxt = S_RUNNING;
            default:   w_state_nxt = S_IDLE;
         endcase
      end else if (r_press[BTN_LAP]) begin
         if (r_state == S_RUNNING) begin
            w_state_nxt = S_LAP;
         end else if (r_state == S_LAP) begin
            w_state_nxt = S_RUNNING;
         end
      end
   end

   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         r_state <= S_IDLE;
         r_en    <= 1'b0;
         r_clr   <= 1'b0;
         r_frz   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_en    <= (w_state_nxt == S_RUNNING) || (w_state_nxt == S_LAP);
         r_clr   <= w_clr_nxt;
         r_frz   <= (w_state_nxt == S_LAP);
      end
   end

   assign enCounterOut     = r_en;
   assign clrCounterOut    = r_clr;
   assign freezeDisplayOut = r_frz;
   assign stateOut         = r_state;

endmodule

// File: tb/tb_stopwatch_control.sv
// Directed bench for stopwatch_control with DEBOUNCE_CYCLES = 4:
// button presses land on the outputs 8 edges after the first high sample.
module tb_stopwatch_control;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       b_ss = 1'b0;
   logic       b_rst = 1'b0;
   logic       b_lap = 1'b0;
   logic       en_o;
   logic       clr_o;
   logic       frz_o;
   logic [1:0] st_o;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] clr_hist;
   logic [1:0]  st_pre;
   logic [1:0]  st_s;
   logic        en_s;
   logic        frz_s;

   stopwatch_control #(.DEBOUNCE_CYCLES(4)) dut (
      .clkIn            (clk),
      .rstIn            (rst),
      .startStopBtnIn   (b_ss),
      .resetBtnIn       (b_rst),
      .lapBtnIn         (b_lap),
      .enCounterOut     (en_o),
      .clrCounterOut    (clr_o),
      .freezeDisplayOut (frz_o),
      .stateOut         (st_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // m = {lap, reset, startStop}; hold 8 edges, sample, release and settle.
   task automatic press(input logic [2:0] m);
      clr_hist = '0;
      {b_lap, b_rst, b_ss} = m;
      for (int t = 0; t < 16; t++) begin
         tick();
         clr_hist[t] = clr_o;
         if (t == 6) st_pre = st_o;
         if (t == 7) begin
            st_s  = st_o;
            en_s  = en_o;
            frz_s = frz_o;
            {b_lap, b_rst, b_ss} = 3'b000;
         end
      end
   endtask

   initial begin
      // reset with all buttons held
      rst = 1'b1;
      {b_lap, b_rst, b_ss} = 3'b111;
      tick();
      check("rst_state_e1", {14'd0, st_o}, 16'h0);
      tick();
      tick();
      check("rst_state", {14'd0, st_o}, 16'h0);
      check("rst_en", {15'd0, en_o}, 16'h0);
      check("rst_clr", {15'd0, clr_o}, 16'h0);
      check("rst_frz", {15'd0, frz_o}, 16'h0);

      rst = 1'b0;
      b_rst = 1'b0;
      b_lap = 1'b0;
      clr_hist = '0;
      for (int e = 1; e <= 10; e++) begin
         tick();
         clr_hist[e] = clr_o;
         if (e == 7) begin
            check("post_rst_e7_state", {14'd0, st_o}, 16'h0);
            check("post_rst_e7_en", {15'd0, en_o}, 16'h0);
         end
         if (e == 8) begin
            check("post_rst_e8_state", {14'd0, st_o}, 16'h1);
            check("post_rst_e8_en", {15'd0, en_o}, 16'h1);
         end
      end
      b_ss = 1'b0;
      for (int e = 0; e < 8; e++) tick();
      check("post_rst_state", {14'd0, st_o}, 16'h1);
      check("post_rst_noclr", clr_hist, 16'h0);

      // bounce rejection from PAUSED
      press(3'b001);
      check("pause_state", {14'd0, st_s}, 16'h2);
      check("pause_en", {15'd0, en_s}, 16'h0);
      b_ss = 1'b1; tick(); tick(); tick();
      b_ss = 1'b0; tick();
      b_ss = 1'b1; tick(); tick(); tick();
      b_ss = 1'b0;
      for (int e = 0; e < 10; e++) tick();
      check("bounce_state", {14'd0, st_o}, 16'h2);
      check("bounce_en", {15'd0, en_o}, 16'h0);
      b_ss = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         tick();
         if (e == 7) check("hold_e7_en", {15'd0, en_o}, 16'h0);
         if (e == 8) check("hold_e8_en", {15'd0, en_o}, 16'h1);
      end
      b_ss = 1'b0;
      for (int e = 0; e < 8; e++) tick();
      check("hold_state", {14'd0, st_o}, 16'h1);

      // back to IDLE, then full sequence
      press(3'b001);
      press(3'b010);
      check("to_idle_state", {14'd0, st_s}, 16'h0);
      press(3'b001);
      check("seq_start_pre", {14'd0, st_pre}, 16'h0);
      check("seq_start_state", {14'd0, st_s}, 16'h1);
      check("seq_start_en", {15'd0, en_s}, 16'h1);
      check("seq_start_frz", {15'd0, frz_s}, 16'h0);
      check("seq_start_clr", clr_hist, 16'h0);
      press(3'b100);
      check("seq_lap_state", {14'd0, st_s}, 16'h3);
      check("seq_lap_en", {15'd0, en_s}, 16'h1);
      check("seq_lap_frz", {15'd0, frz_s}, 16'h1);
      press(3'b100);
      check("seq_unlap_state", {14'd0, st_s}, 16'h1);
      check("seq_unlap_en", {15'd0, en_s}, 16'h1);
      check("seq_unlap_frz", {15'd0, frz_s}, 16'h0);
      press(3'b001);
      check("seq_stop_state", {14'd0, st_s}, 16'h2);
      check("seq_stop_en", {15'd0, en_s}, 16'h0);
      check("seq_stop_frz", {15'd0, frz_s}, 16'h0);
      press(3'b010);
      check("seq_clear_pre", {14'd0, st_pre}, 16'h2);
      check("seq_clear_state", {14'd0, st_s}, 16'h0);
      check("seq_clear_en", {15'd0, en_s}, 16'h0);
      check("seq_clear_clr", clr_hist, 16'h0080);

      // ignored presses
      press(3'b001);
      press(3'b010);
      check("ign_rst_state", {14'd0, st_s}, 16'h1);
      check("ign_rst_clr", clr_hist, 16'h0);
      press(3'b001);
      press(3'b010);
      press(3'b100);
      check("ign_lap_state", {14'd0, st_s}, 16'h0);
      check("ign_lap_frz", {15'd0, frz_s}, 16'h0);

      // simultaneous presses
      press(3'b001);
      press(3'b001);
      check("sim_paused_pre", {14'd0, st_s}, 16'h2);
      press(3'b011);
      check("sim_rst_state", {14'd0, st_s}, 16'h0);
      check("sim_rst_en", {15'd0, en_s}, 16'h0);
      check("sim_rst_clr", clr_hist, 16'h0080);
      press(3'b001);
      press(3'b101);
      check("sim_ss_state", {14'd0, st_s}, 16'h2);
      check("sim_ss_frz", {15'd0, frz_s}, 16'h0);

      // reset during LAP with a lap debounce in flight
      press(3'b001);
      press(3'b100);
      check("mid_lap_state", {14'd0, st_s}, 16'h3);
      b_lap = 1'b1;
      tick(); tick(); tick(); tick();
      b_lap = 1'b0;
      rst = 1'b1;
      tick();
      check("mid_rst_state", {14'd0, st_o}, 16'h0);
      check("mid_rst_en", {15'd0, en_o}, 16'h0);
      check("mid_rst_clr", {15'd0, clr_o}, 16'h0);
      check("mid_rst_frz", {15'd0, frz_o}, 16'h0);
      rst = 1'b0;
      clr_hist = '0;
      for (int e = 0; e < 12; e++) begin
         tick();
         clr_hist[e] = clr_o | frz_o | en_o | (st_o != 2'b00);
      end
      check("mid_rst_quiet", clr_hist, 16'h0);
      check("mid_rst_final_state", {14'd0, st_o}, 16'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
